// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV64M multiply/divide unit for the EX stage.
//   Radix-2 shift-add multiplier and restoring divider, one bit per cycle.
//   Divide-by-zero and signed overflow are resolved at accept time.
// Ports:
//   clock, reset (async, active-low)
//   valid_i, funct3_i, word_i, srcA_i, srcB_i, rd_i : request from decode
//   flush_i  : aborts an op in CALC/FIX, blocks accept in IDLE
//   ready_o  : high only in IDLE
//   done_o   : one-cycle pulse, result_o/rd_o valid
//   result_o, rd_o : registered result and destination tag
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request, ready_o high
// CALC  | one partial product / quotient bit per cycle, N cycles
// FIX   | sign correction and result selection
// DONE  | result_o/rd_o valid, done_o high for this one cycle
module ex_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] srcA_i,
    input  logic [XLEN-1:0] srcB_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              word_q, word_d;
    logic              neg_q, neg_d;       // result sign (product / quotient)
    logic              sa_q, sa_d;         // dividend sign, for the remainder
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplr_q, mplr_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [4:0]        tag_q, tag_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_q, rd_d;

    logic              accept, sgn_a, sgn_b, a_neg, b_neg, div0, ovf, last;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, a_sext32, special_res;
    logic [XLEN-1:0]   quo_f, rem_f, div_sel, fix_res;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     rsh;

    // Operand preparation for the request currently on the inputs.
    always_comb begin
        sgn_a    = !(funct3_i == 3'd3 || funct3_i == 3'd5 || funct3_i == 3'd7);
        sgn_b    = sgn_a && (funct3_i != 3'd2);
        a_sext32 = {{32{srcA_i[31]}}, srcA_i[31:0]};
        a_ext    = word_i ? {{32{sgn_a & srcA_i[31]}}, srcA_i[31:0]} : srcA_i;
        b_ext    = word_i ? {{32{sgn_b & srcB_i[31]}}, srcB_i[31:0]} : srcB_i;
        a_neg    = sgn_a & a_ext[XLEN-1];
        b_neg    = sgn_b & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div0     = (b_ext == '0);
        ovf      = sgn_a && (b_ext == '1) &&
                   (a_ext == (word_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        if (funct3_i[1])
            special_res = div0 ? (word_i ? a_sext32 : srcA_i) : '0;
        else
            special_res = div0 ? '1 : a_ext;
    end

    // Final result, evaluated in FIX from the iteration registers.
    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        quo_f   = neg_q ? -quo_q : quo_q;
        rem_f   = sa_q ? -rem_q : rem_q;
        div_sel = op_q[1] ? rem_f : quo_f;
        if (op_q[2])
            fix_res = word_q ? {{32{div_sel[31]}}, div_sel[31:0]} : div_sel;
        else if (op_q[1:0] == 2'd0)
            fix_res = word_q ? {{32{prod[31]}}, prod[31:0]} : prod[XLEN-1:0];
        else
            fix_res = prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        word_d   = word_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        tag_d    = tag_q;
        result_d = result_q;
        rd_d     = rd_q;
        accept   = valid_i && (state_q == S_IDLE) && !flush_i;
        last     = (cnt_q == (word_q ? 6'd31 : 6'd63));
        rsh      = {rem_q, quo_q[XLEN-1]};

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    op_d    = funct3_i;
                    word_d  = word_i;
                    tag_d   = rd_i;
                    neg_d   = a_neg ^ b_neg;
                    sa_d    = a_neg;
                    acc_d   = '0;
                    mcand_d = {{XLEN{1'b0}}, a_mag};
                    mplr_d  = b_mag;
                    // Word dividends start at the top so 32 steps consume them.
                    quo_d   = word_i ? (a_mag << 32) : a_mag;
                    rem_d   = '0;
                    dvs_d   = b_mag;
                    if (funct3_i[2] && (div0 || ovf)) begin
                        state_d  = S_DONE;
                        result_d = special_res;
                        rd_d     = rd_i;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (last)
                        state_d = S_FIX;
                    if (op_q[2]) begin
                        if (rsh >= {1'b0, dvs_q}) begin
                            // Difference is below the divisor, so 64 bits suffice.
                            rem_d = rsh[XLEN-1:0] - dvs_q;
                            quo_d = {quo_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_d = rsh[XLEN-1:0];
                            quo_d = {quo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        if (mplr_q[0])
                            acc_d = acc_q + mcand_q;
                        mcand_d = mcand_q << 1;
                        mplr_d  = mplr_q >> 1;
                    end
                end
            end
            S_FIX: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    result_d = fix_res;
                    rd_d     = tag_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            tag_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign rd_o     = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed-vector bench for ex_muldiv with hand-computed results.
//   Latency is counted in clock edges from the accept edge (inclusive) to the
//   edge that enters DONE: N+2 for iterative ops, 1 for resolved special cases.
module tb_ex_muldiv;

    logic        clock;
    logic        reset;
    logic        valid_i;
    logic [2:0]  funct3_i;
    logic        word_i;
    logic [63:0] srcA_i;
    logic [63:0] srcB_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        ready_o;
    logic        done_o;
    logic [63:0] result_o;
    logic [4:0]  rd_o;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] last_res = '0;

    ex_muldiv #(.XLEN(64)) dut (
        .clock    (clock),
        .reset    (reset),
        .valid_i  (valid_i),
        .funct3_i (funct3_i),
        .word_i   (word_i),
        .srcA_i   (srcA_i),
        .srcB_i   (srcB_i),
        .rd_i     (rd_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        @(negedge clock);
        valid_i  = 1'b1;
        funct3_i = f3;
        word_i   = w;
        srcA_i   = a;
        srcB_i   = b;
        rd_i     = rd;
        @(posedge clock);
        #1 valid_i = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                          input logic [63:0] exp_res, input int exp_lat);
        int   lat;
        logic rdy_seen;
        drive(f3, w, a, b, rd);
        lat      = 1;
        rdy_seen = 1'b0;
        while (!done_o && lat < 200) begin
            if (ready_o) rdy_seen = 1'b1;
            @(posedge clock);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, result_o, exp_res);
        chk({tag, "_rd"}, 64'(rd_o), 64'(rd));
        chk({tag, "_busy_rdy"}, 64'(rdy_seen | ready_o), 64'd0);
        @(posedge clock);
        #1;
        chk({tag, "_pulse"}, 64'(done_o), 64'd0);
        chk({tag, "_rdy_after"}, 64'(ready_o), 64'd1);
        last_res = exp_res;
    endtask

    initial begin
        reset    = 1'b0;
        valid_i  = 1'b0;
        funct3_i = '0;
        word_i   = 1'b0;
        srcA_i   = '0;
        srcB_i   = '0;
        rd_i     = '0;
        flush_i  = 1'b0;
        #12;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_rd", 64'(rd_o), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op("mul",    3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 66);
        run_op("mulhu",  3'd3, 1'b0, '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("mulh",   3'd1, 1'b0, '1, '1, 5'd3, 64'd0, 66);
        run_op("mulhsu", 3'd2, 1'b0, '1, '1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("div",    3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("rem",    3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("divu",   3'd5, 1'b0, 64'd100, 64'd7, 5'd7, 64'd14, 66);
        run_op("remu",   3'd7, 1'b0, 64'd100, 64'd7, 5'd8, 64'd2, 66);
        run_op("divu0",  3'd5, 1'b0, 64'h1234, 64'd0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("rem0",   3'd6, 1'b0, 64'h1234, 64'd0, 5'd10, 64'h1234, 1);
        run_op("divovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd11, 64'h8000_0000_0000_0000, 1);
        run_op("divwovf",3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 5'd12, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("divuw",  3'd5, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 5'd13, 64'h0000_0000_7FFF_FFFF, 34);
        run_op("mulw",   3'd0, 1'b1, 64'h10000, 64'h10000, 5'd14, 64'd0, 34);
        run_op("remw",   3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 5'd15,
               64'hFFFF_FFFF_FFFF_FFFF, 34);
        run_op("remuw0", 3'd7, 1'b1, 64'h0000_0000_8000_0001, 64'h5555_0000_0000_0000, 5'd16,
               64'hFFFF_FFFF_8000_0001, 1);

        // Flush with valid in IDLE must not start an op.
        @(negedge clock);
        valid_i  = 1'b1;
        flush_i  = 1'b1;
        funct3_i = 3'd0;
        srcA_i   = 64'd9;
        srcB_i   = 64'd9;
        @(posedge clock);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        chk("idle_flush_rdy", 64'(ready_o), 64'd1);

        // Flush a DIV at its tenth busy cycle, then start a MUL right away.
        drive(3'd4, 1'b0, 64'd1000, 64'd3, 5'd20);
        repeat (9) @(posedge clock);
        @(negedge clock);
        chk("pre_flush_busy", 64'(ready_o), 64'd0);
        flush_i = 1'b1;
        @(posedge clock);
        #1;
        flush_i = 1'b0;
        chk("flush_rdy", 64'(ready_o), 64'd1);
        chk("flush_done", 64'(done_o), 64'd0);
        chk("flush_hold", result_o, last_res);
        run_op("mul_b2b", 3'd0, 1'b0, 64'd3, 64'd5, 5'd21, 64'd15, 66);

        // Reset in the middle of a MUL.
        drive(3'd0, 1'b0, 64'd11, 64'd13, 5'd22);
        repeat (19) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("mrst_ready", 64'(ready_o), 64'd1);
        chk("mrst_done", 64'(done_o), 64'd0);
        chk("mrst_result", result_o, 64'd0);
        chk("mrst_rd", 64'(rd_o), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        run_op("post_rst", 3'd0, 1'b0, 64'd2, 64'd3, 5'd23, 64'd6, 66);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
